icache_refill: RTL
==================

Name: icache_refill

Overview:
- Miss-side refill engine for the instruction cache; drives the cache's fill port (fill enable, fill address, fill word).
- On a fetch miss, it reads the 32-bit instruction from the byte-wide memory controller one byte at a time and assembles the bytes little-endian.
- It then writes the word into the cache and forwards it to the fetch stage in the same cycle.
- It sits between the fetch stage, the instruction cache and the memory arbiter.

Parameters:
ADDR_W, 32, address width
INST_BYTES, 4, bytes fetched per instruction (fixed at 4; parameter only documents byte-counter width)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low = freeze all state, outputs hold
miss_valid  in  1  fetch stage reports cache miss for miss_addr
miss_addr  in  ADDR_W  PC that missed
flush  in  1  branch mispredict/clear; abort any refill
mem_req  out  1  byte read request to memory arbiter
mem_addr  out  ADDR_W  byte address of current request
mem_ready  in  1  pulse: mem_data valid for current request
mem_data  in  8  returned byte
fill_en  out  1  one-cycle write strobe to icache
fill_addr  out  ADDR_W  word address written
fill_inst  out  32  instruction written
inst_valid  out  1  one-cycle strobe to fetch stage
inst_out  out  32  instruction delivered (equals fill_inst)
inst_pc  out  ADDR_W  PC of inst_out (equals fill_addr)
busy  out  1  refill in progress (state != IDLE)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, byte count=0, assembly register=0.
- Output reset values: mem_req=0, mem_addr=0, fill_en=0, fill_addr=0, fill_inst=0, inst_valid=0, inst_out=0, inst_pc=0, busy=0.
- Reset overrides rdy and any operation in flight. A mem_ready arriving after reset is ignored.
- rdy=0: no state, counter or output register changes; mem_ready/mem_data in that cycle are ignored. The arbiter must not pulse mem_ready while rdy=0.
- States:
  - IDLE: accepts a miss.
  - FETCH: byte loop.
  - DONE: single-cycle fill/deliver.
- IDLE, miss_valid=1 and flush=0 at edge N:
  - latch base = {miss_addr[ADDR_W-1:2],2'b00} (low two bits ignored).
  - count=0; go to FETCH.
  - from N+1: mem_req=1, mem_addr=base.
- FETCH:
  - mem_req held 1, mem_addr = base + count, until mem_ready.
  - On mem_ready: byte[count] <= mem_data (bits 8*count+7 : 8*count), count <= count+1.
  - mem_addr advances the following cycle.
  - mem_ready on count=3: mem_req drops to 0 next cycle; go to DONE.
  - Each byte is an independent request/ack. A mem_ready wait of any length is legal, with no timeout.
- DONE (one cycle):
  - fill_en=1, inst_valid=1.
  - fill_addr = inst_pc = base; fill_inst = inst_out = assembled word.
  - Next state IDLE.
  - fill_en and inst_valid are registered outputs, asserted only during DONE. fill_addr/fill_inst/inst_out/inst_pc hold their last values otherwise.
- Latency, zero-wait memory (mem_ready on every cycle mem_req=1): miss accepted at edge N, bytes at edges N+1..N+4, fill/deliver strobes visible in cycle N+5.
- miss_valid while busy: ignored. The fetch stage re-presents the miss after a deliver or flush.
- flush (rdy=1):
  - From FETCH or DONE: go to IDLE next edge; mem_req=0, fill_en=0, inst_valid=0 next cycle.
  - No cache write and no delivery for the aborted PC.
  - flush together with the final mem_ready: abort wins, no fill.
  - flush together with miss_valid in IDLE: miss not accepted.
- Stray mem_ready in IDLE or DONE (late ack after a flush): ignored.
- Byte-address arithmetic is modulo 2^ADDR_W.

Decomposition:
- Shared package (cpu_defs): ADDR_W, INST_W=32, and the state encoding localparams IDLE/FETCH/DONE.
- No sub-module required.
- Byte assembly is a 32-bit shift/insert register indexed by the 2-bit counter, kept inline.

Test Plan:
- Basic miss, zero-wait: miss_addr=0x00001004; mem_data 0x13,0x05,0x10,0x00 returned for mem_addr 0x1004..0x1007 -> one-cycle fill_en=inst_valid=1, fill_addr=0x00001004, fill_inst=0x00100513, 5 cycles after accept.
- Misaligned PC and wait states: miss_addr=0x00002006; mem_ready delayed 3 cycles per byte; bytes 0xB7,0x02,0x00,0x80 -> mem_addr sequence 0x2004..0x2007; fill_inst=0x800002B7; mem_req held steady during waits.
- Flush mid-refill: flush after 2 bytes, then a late mem_ready -> no fill_en/inst_valid; busy=0; next miss 0x3000 completes normally with count restarting at 0.
- Flush on last byte: flush coincident with the 4th mem_ready -> no fill; state IDLE next cycle.
- rdy stall: rdy=0 for 4 cycles in FETCH (no mem_ready in that window) -> mem_addr/count/outputs frozen; completes correctly after rdy=1.
- Reset mid-operation and miss while busy: rst during FETCH -> all outputs 0 next cycle; a second miss_valid (0x4000) while busy -> ignored; only the first PC is filled.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions for the fetch-side blocks.
// This package holds the address/instruction widths and the refill state encoding.
package cpu_defs;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t FETCH = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/icache_refill.sv
// Instruction-cache miss refill: fetches a 32-bit instruction byte by byte,
// assembles it little-endian, then fills the cache and delivers it to fetch.
module icache_refill #(
    parameter int ADDR_W     = cpu_defs::ADDR_W,
    parameter int INST_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [7:0]        mem_data,
    output logic              fill_en,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [31:0]       fill_inst,
    output logic              inst_valid,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              busy
);
    import cpu_defs::*;

    localparam int CNT_W = $clog2(INST_BYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(INST_BYTES - 1);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   base, base_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [INST_W-1:0]   asm_word, asm_nx;

    logic                mem_req_nx, fill_en_nx, inst_valid_nx;
    logic [ADDR_W-1:0]   mem_addr_nx, fill_addr_nx;
    logic [INST_W-1:0]   fill_inst_nx;

    logic accept;
    // The refill is always word-aligned, so the PC's byte offset is dropped.
    logic unused_lo;
    assign unused_lo = ^miss_addr[1:0];

    assign accept = (state == IDLE) && miss_valid && !flush;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (rdy)
            state <= state_nx;
    end

    // Next-state logic; flush aborts from any busy state, beating a final ack
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = FETCH;
            FETCH: begin
                if (flush)
                    state_nx = IDLE;
                else if (mem_ready && cnt == LAST)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath next values: base latch, byte counter, assembly register
    always_comb begin
        base_nx = base;
        cnt_nx  = cnt;
        asm_nx  = asm_word;
        case (state)
            IDLE: begin
                if (accept) begin
                    base_nx = {miss_addr[ADDR_W-1:2], 2'b00};
                    cnt_nx  = '0;
                    asm_nx  = '0;
                end
            end
            FETCH: begin
                if (mem_ready && !flush) begin
                    asm_nx[{cnt, 3'b000} +: 8] = mem_data;
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output logic: every output is registered off the next state
    always_comb begin
        mem_req_nx    = (state_nx == FETCH);
        mem_addr_nx   = mem_addr;
        fill_en_nx    = (state_nx == DONE);
        inst_valid_nx = (state_nx == DONE);
        fill_addr_nx  = fill_addr;
        fill_inst_nx  = fill_inst;
        if (state_nx == FETCH)
            mem_addr_nx = base_nx + ADDR_W'(cnt_nx);
        if (state_nx == DONE) begin
            fill_addr_nx = base;
            fill_inst_nx = asm_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base       <= '0;
            cnt        <= '0;
            asm_word   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            fill_en    <= 1'b0;
            inst_valid <= 1'b0;
            fill_addr  <= '0;
            fill_inst  <= '0;
        end else if (rdy) begin
            base       <= base_nx;
            cnt        <= cnt_nx;
            asm_word   <= asm_nx;
            mem_req    <= mem_req_nx;
            mem_addr   <= mem_addr_nx;
            fill_en    <= fill_en_nx;
            inst_valid <= inst_valid_nx;
            fill_addr  <= fill_addr_nx;
            fill_inst  <= fill_inst_nx;
        end
    end

    assign inst_out = fill_inst;
    assign inst_pc  = fill_addr;
    assign busy     = (state != IDLE);

endmodule
